clb_cfg_loader: RTL
===================

// Module: clb_cfg_loader
// PURPOSE
//  Byte-serial configuration loader feeding the CLB fabric in tt_um_gmejiamtz.
//  Receives framed configuration bytes from the pad inputs, assembles them in a
//  shadow register and verifies an XOR checksum. On a good frame it atomically
//  commits the shadow to cfg_out, the CLB's LUT/mux configuration word.
//  Bad or aborted frames never disturb the active configuration.
// PARAMETERS
//  CFG_BITS        64     config word width; multiple of 8; NBYTES = CFG_BITS/8
//  SYNC_BYTE       8'hA5  frame start marker
//  CFG_INIT        '0     cfg_out value after reset (CFG_BITS wide)
//  TIMEOUT_CYCLES  255    idle-gap limit inside a frame (used only with CLB_CFG_TIMEOUT_EN)
// PORTS
//  clk         in   1         clock
//  rst         in   1         synchronous reset, active-high
//  in_data     in   8         configuration byte
//  in_valid    in   1         in_data valid
//  in_ready    out  1         loader can accept a byte
//  cfg_out     out  CFG_BITS  active configuration word to the CLB
//  cfg_load    out  1         1-cycle pulse: cfg_out updated this cycle
//  cfg_loaded  out  1         sticky: at least one good frame committed since reset
//  busy        out  1         frame in progress (state != IDLE)
//  err_chk     out  1         sticky checksum error; cleared on next SYNC accept
//  err_to      out  1         sticky timeout error; cleared on next SYNC accept
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, cfg_out=CFG_INIT, shadow=0, byte count=0,
//    checksum acc=0, cfg_load=0, cfg_loaded=0, busy=0, err_chk=0, err_to=0.
//    Reset mid-frame discards the partial frame. in_ready=1 out of reset.
//  - Byte accept = in_valid & in_ready at a rising clk edge.
//  - States: IDLE -> LOAD -> CKSUM -> COMMIT -> IDLE.
//  - IDLE: in_ready=1. Accepted non-SYNC bytes are discarded. On an accepted SYNC_BYTE:
//    go to LOAD; clear count, acc, err_chk and err_to.
//  - LOAD: in_ready=1. Payload byte k (k=0..NBYTES-1) is written to shadow[8k+7:8k].
//    acc ^= byte. After byte NBYTES-1 is accepted, go to CKSUM.
//    A SYNC_BYTE value in LOAD is ordinary payload; there is no resync.
//  - CKSUM: in_ready=1. Accepted byte == acc -> COMMIT. Otherwise set err_chk=1 at that
//    edge, go to IDLE, and leave cfg_out unchanged.
//  - COMMIT: in_ready=0 for exactly one cycle. At the edge leaving COMMIT:
//    cfg_out<=shadow, cfg_loaded<=1, cfg_load=1 for the following cycle only.
//    Then IDLE.
//  - Latency: the new cfg_out is visible 2 edges after the checksum byte is accepted.
//    The earliest next SYNC accept is the cycle cfg_load is high.
//  - in_valid gaps are legal in every state. A held byte stays pending until accepted.
//  - busy = (state != IDLE), registered with the state.
// CONFIGURATION
//  `CLB_CFG_TIMEOUT_EN defined: a gap counter runs in LOAD/CKSUM. It resets on each
//    accepted byte and increments on every other cycle. When it reaches TIMEOUT_CYCLES:
//    err_to=1, go to IDLE, discard the shadow, leave cfg_out unchanged.
//  Not defined: no counter; a frame waits indefinitely; err_to is tied 0.
// TESTING
//  1. rst=1 for 2 cycles -> cfg_out=0, cfg_loaded=0, busy=0, in_ready=1, errs=0.
//  2. Send A5,01,02,03,04,05,06,07,08,08 back-to-back -> cfg_out=64'h0807060504030201,
//     one cfg_load pulse 2 edges after the last byte, cfg_loaded=1, err_chk=0.
//  3. Same frame with checksum 09 -> err_chk=1, no cfg_load, cfg_out unchanged.
//     Then a good frame -> err_chk clears on A5 and the new cfg_out commits.
//  4. Send 00,FF,3C, then the frame from test 2 with random in_valid gaps and one
//     payload byte = A5 (checksum adjusted) -> junk ignored, correct commit, single pulse.
//  5. Assert rst after 4 payload bytes, then send a full new frame -> cfg_out=CFG_INIT
//     after reset, busy=0, and the new frame commits correctly.
//  6. TIMEOUT_CYCLES=16, send A5 + 3 bytes then idle.
//     With macro -> err_to=1 and busy=0 after 16 cycles.
//     Without macro -> no error after 1000 cycles; the resumed frame commits.

Source files
------------

// File: rtl/clb_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// clb_cfg_loader_if
//   Byte-stream handshake carrying configuration bytes into clb_cfg_loader.
//   A byte transfers on a rising clock edge when in_valid and in_ready are
//   both high.
// Signals
//   in_data   [7:0]  configuration byte            (master -> slave)
//   in_valid         in_data holds a byte           (master -> slave)
//   in_ready         slave can accept a byte now    (slave  -> master)
// Modports
//   master : byte source (pads / testbench)
//   slave  : the loader
// ---------------------------------------------------------------------------
interface clb_cfg_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/clb_cfg_loader.sv
// ---------------------------------------------------------------------------
// clb_cfg_loader
//   Byte-serial configuration loader for the CLB fabric. A frame is
//   SYNC_BYTE, NBYTES payload bytes (little-endian into the word) and one
//   XOR checksum byte. Payload is assembled in a shadow register; only a
//   frame whose checksum matches is committed to cfg_out, so bad, aborted
//   or timed-out frames never disturb the active configuration.
// Ports
//   clk         clock
//   rst         synchronous reset, active-high
//   cfg_in      byte handshake (clb_cfg_loader_if.slave)
//   cfg_out     active configuration word to the CLB
//   cfg_load    1-cycle pulse: cfg_out updated this cycle
//   cfg_loaded  sticky: a good frame was committed since reset
//   busy        frame in progress
//   err_chk     sticky checksum error, cleared by the next accepted SYNC
//   err_to      sticky timeout error, cleared by the next accepted SYNC
// Build option
//   CLB_CFG_TIMEOUT_EN : when defined, a frame stalled for TIMEOUT_CYCLES
//                        cycles in LOAD/CKSUM is abandoned with err_to=1.
//                        When undefined a frame waits forever, err_to=0.
// ---------------------------------------------------------------------------
module clb_cfg_loader #(
  parameter int                  CFG_BITS       = 64,
  parameter logic [7:0]          SYNC_BYTE      = 8'hA5,
  parameter logic [CFG_BITS-1:0] CFG_INIT       = '0,
  parameter int                  TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  clb_cfg_loader_if.slave     cfg_in,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_load,
  output logic                cfg_loaded,
  output logic                busy,
  output logic                err_chk,
  output logic                err_to
);

  localparam int NBYTES = CFG_BITS / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Elaboration-time parameter sanity checks.
  if ((CFG_BITS % 8) != 0 || CFG_BITS < 8) begin : g_bad_cfg_bits
    $error("clb_cfg_loader: CFG_BITS must be a positive multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("clb_cfg_loader: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CKSUM  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t              state, next_state;
  logic [CFG_BITS-1:0] shadow;
  logic [CNT_W-1:0]    count;
  logic [7:0]          acc;
  logic                ready;
  logic                accept;
  logic                sync_start;
  logic                chk_fail;
  logic                timeout;

`ifdef CLB_CFG_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap;
`endif

  // COMMIT is the only state that stalls the byte stream.
  assign ready           = (state != ST_COMMIT);
  assign cfg_in.in_ready = ready;
  assign accept          = cfg_in.in_valid & ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    next_state = state;
    sync_start = 1'b0;
    chk_fail   = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && cfg_in.in_data == SYNC_BYTE) begin
          next_state = ST_LOAD;
          sync_start = 1'b1;
        end
      end
      ST_LOAD: begin
        // SYNC_BYTE is ordinary payload here; there is no resync.
        if (accept && count == CNT_W'(NBYTES - 1)) next_state = ST_CKSUM;
      end
      ST_CKSUM: begin
        if (accept) begin
          if (cfg_in.in_data == acc) begin
            next_state = ST_COMMIT;
          end else begin
            next_state = ST_IDLE;
            chk_fail   = 1'b1;
          end
        end
      end
      default: next_state = ST_IDLE;   // ST_COMMIT lasts exactly one cycle
    endcase
`ifdef CLB_CFG_TIMEOUT_EN
    // The gap that reaches the limit is an idle cycle, so it never
    // coincides with an accepted byte.
    if ((state == ST_LOAD || state == ST_CKSUM) && !accept &&
        gap == GAP_W'(TIMEOUT_CYCLES - 1)) begin
      next_state = ST_IDLE;
      timeout    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      cfg_out    <= CFG_INIT;
      shadow     <= '0;
      count      <= '0;
      acc        <= '0;
      cfg_load   <= 1'b0;
      cfg_loaded <= 1'b0;
      err_chk    <= 1'b0;
    end else begin
      state    <= next_state;
      busy     <= (next_state != ST_IDLE);
      cfg_load <= (state == ST_COMMIT);

      if (state == ST_COMMIT) begin
        cfg_out    <= shadow;
        cfg_loaded <= 1'b1;
      end

      if (sync_start) begin
        count   <= '0;
        acc     <= '0;
        err_chk <= 1'b0;
      end

      if (state == ST_LOAD && accept) begin
        shadow[8*int'(count) +: 8] <= cfg_in.in_data;
        acc                        <= acc ^ cfg_in.in_data;
        count                      <= count + CNT_W'(1);
      end

      if (chk_fail) err_chk <= 1'b1;
      if (timeout)  shadow  <= '0;
    end
  end

`ifdef CLB_CFG_TIMEOUT_EN
  // Gap counter: idle cycles since the last accepted byte while in a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap    <= '0;
      err_to <= 1'b0;
    end else begin
      if (sync_start) err_to <= 1'b0;
      if (timeout)    err_to <= 1'b1;
      if (accept || !(state == ST_LOAD || state == ST_CKSUM) || timeout)
        gap <= '0;
      else
        gap <= gap + GAP_W'(1);
    end
  end
`else
  assign err_to = 1'b0;
`endif

endmodule
